// File: rtl/branch_resolve_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_resolve_queue_if : push/resolve/update bundle for the branch queue |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
interface branch_resolve_queue_if #(
  parameter int PTR_BITS = 2,
  parameter int CNT_W    = 16
);
  logic                push_valid;
  logic                push_ready;
  logic [31:0]         push_pc4;
  logic [31:0]         push_target;
  logic                push_pred_taken;
  logic                resolve_valid;
  logic [5:0]          resolve_opcode;
  logic                resolve_equal;
  logic                upd_valid;
  logic [31:0]         upd_pc4;
  logic                upd_pred_wrong;
  logic                upd_real_taken;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;
  logic [PTR_BITS:0]   occupancy;
  logic                err;
  logic [CNT_W-1:0]    branch_cnt;
  logic [CNT_W-1:0]    mispred_cnt;

  modport master (
    output push_valid, push_pc4, push_target, push_pred_taken,
    output resolve_valid, resolve_opcode, resolve_equal,
    input  push_ready, upd_valid, upd_pc4, upd_pred_wrong, upd_real_taken,
    input  redirect_valid, redirect_pc, occupancy, err, branch_cnt, mispred_cnt
  );

  modport slave (
    input  push_valid, push_pc4, push_target, push_pred_taken,
    input  resolve_valid, resolve_opcode, resolve_equal,
    output push_ready, upd_valid, upd_pc4, upd_pred_wrong, upd_real_taken,
    output redirect_valid, redirect_pc, occupancy, err, branch_cnt, mispred_cnt
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_resolve_queue : in-order IF->ID branch prediction tracker          |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module branch_resolve_queue #(
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2,
  parameter int CNT_W    = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  branch_resolve_queue_if.slave  bus
);
  localparam logic [5:0]        c_OP_BEQ = 6'b000100;
  localparam logic [5:0]        c_OP_BNE = 6'b000101;
  localparam logic [PTR_BITS:0] c_DEPTH  = (PTR_BITS+1)'(DEPTH);

  logic [31:0]          r_pc4  [DEPTH];
  logic [31:0]          r_tgt  [DEPTH];
  logic                 r_pred [DEPTH];
  logic [PTR_BITS-1:0]  r_head;
  logic [PTR_BITS-1:0]  r_tail;
  logic [PTR_BITS:0]    r_count;

  logic                 r_upd_valid;
  logic [31:0]          r_upd_pc4;
  logic                 r_upd_wrong;
  logic                 r_upd_taken;
  logic                 r_redirect_valid;
  logic [31:0]          r_redirect_pc;
  logic                 r_err;
  logic [CNT_W-1:0]     r_branch_cnt;
  logic [CNT_W-1:0]     r_mispred_cnt;

  logic                 w_push_ready;
  logic                 w_is_branch;
  logic                 w_res_acc;
  logic                 w_real_taken;
  logic                 w_wrong;
  logic                 w_flush;
  logic                 w_push_acc;
  logic [PTR_BITS:0]    w_count_nxt;

  assign w_push_ready = (r_count != c_DEPTH);
  assign w_is_branch  = (bus.resolve_opcode == c_OP_BEQ) || (bus.resolve_opcode == c_OP_BNE);
  assign w_res_acc    = bus.resolve_valid && (r_count != '0) && w_is_branch;
  // BEQ and BNE differ only in opcode bit 0.
  assign w_real_taken = bus.resolve_opcode[0] ? !bus.resolve_equal : bus.resolve_equal;
  assign w_wrong      = w_real_taken ^ r_pred[r_head];
  assign w_flush      = w_res_acc && w_wrong;
  // A push racing a mispredict is on the wrong path and is dropped.
  assign w_push_acc   = bus.push_valid && w_push_ready && !w_flush;

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push_acc, w_res_acc})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_pc4[r_tail]  <= bus.push_pc4;
      r_tgt[r_tail]  <= bus.push_target;
      r_pred[r_tail] <= bus.push_pred_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_upd_valid      <= 1'b0;
      r_upd_pc4        <= '0;
      r_upd_wrong      <= 1'b0;
      r_upd_taken      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_err            <= 1'b0;
      r_branch_cnt     <= '0;
      r_mispred_cnt    <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push_acc) r_tail <= r_tail + 1'b1;
      if (w_flush)        r_head <= r_tail;
      else if (w_res_acc) r_head <= r_head + 1'b1;

      r_upd_valid      <= w_res_acc;
      r_redirect_valid <= w_flush;
      if (w_res_acc) begin
        r_upd_pc4     <= r_pc4[r_head];
        r_upd_wrong   <= w_wrong;
        r_upd_taken   <= w_real_taken;
        r_redirect_pc <= w_real_taken ? r_tgt[r_head] : r_pc4[r_head];
        if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
        if (w_wrong && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
      if (bus.resolve_valid && !w_res_acc) r_err <= 1'b1;
    end
  end

  assign bus.push_ready     = w_push_ready;
  assign bus.upd_valid      = r_upd_valid;
  assign bus.upd_pc4        = r_upd_pc4;
  assign bus.upd_pred_wrong = r_upd_wrong;
  assign bus.upd_real_taken = r_upd_taken;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.occupancy      = r_count;
  assign bus.err            = r_err;
  assign bus.branch_cnt     = r_branch_cnt;
  assign bus.mispred_cnt    = r_mispred_cnt;
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_resolve_queue : directed vectors for branch_resolve_queue      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_branch_resolve_queue;
  localparam logic [5:0] c_BEQ = 6'b000100;
  localparam logic [5:0] c_BNE = 6'b000101;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  branch_resolve_queue_if #(.PTR_BITS(2), .CNT_W(4)) bus ();

  branch_resolve_queue #(.DEPTH(4), .PTR_BITS(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc4, input logic [31:0] tgt, input logic pred);
    bus.push_valid = 1'b1; bus.push_pc4 = pc4; bus.push_target = tgt; bus.push_pred_taken = pred;
    cyc();
    bus.push_valid = 1'b0;
  endtask

  task automatic resolve(input logic [5:0] op, input logic eq);
    bus.resolve_valid = 1'b1; bus.resolve_opcode = op; bus.resolve_equal = eq;
    cyc();
    bus.resolve_valid = 1'b0;
  endtask

  task automatic push_resolve(input logic [31:0] pc4, input logic pred, input logic [5:0] op, input logic eq);
    bus.push_valid = 1'b1; bus.push_pc4 = pc4; bus.push_target = 32'h0; bus.push_pred_taken = pred;
    bus.resolve_valid = 1'b1; bus.resolve_opcode = op; bus.resolve_equal = eq;
    cyc();
    bus.push_valid = 1'b0; bus.resolve_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    rst = 1'b1;
    bus.push_valid = 1'b0; bus.push_pc4 = '0; bus.push_target = '0; bus.push_pred_taken = 1'b0;
    bus.resolve_valid = 1'b0; bus.resolve_opcode = '0; bus.resolve_equal = 1'b0;
    cyc(); cyc();
    chk("rst_occ",      32'(bus.occupancy), 0);
    chk("rst_ready",    32'(bus.push_ready), 1);
    chk("rst_upd",      32'(bus.upd_valid), 0);
    chk("rst_redir",    32'(bus.redirect_valid), 0);
    chk("rst_err",      32'(bus.err), 0);
    chk("rst_bcnt",     32'(bus.branch_cnt), 0);
    rst = 1'b0;
    cyc();

    // Single mispredicted BEQ
    push(32'h104, 32'h200, 1'b0);
    chk("t1_occ_push", 32'(bus.occupancy), 1);
    resolve(c_BEQ, 1'b1);
    chk("t1_upd",     32'(bus.upd_valid), 1);
    chk("t1_pc4",     bus.upd_pc4, 32'h104);
    chk("t1_wrong",   32'(bus.upd_pred_wrong), 1);
    chk("t1_taken",   32'(bus.upd_real_taken), 1);
    chk("t1_redir",   32'(bus.redirect_valid), 1);
    chk("t1_rpc",     bus.redirect_pc, 32'h200);
    chk("t1_occ",     32'(bus.occupancy), 0);
    chk("t1_mcnt",    32'(bus.mispred_cnt), 1);
    chk("t1_bcnt",    32'(bus.branch_cnt), 1);
    cyc();
    chk("t1_upd_drop",  32'(bus.upd_valid), 0);
    chk("t1_redir_drop",32'(bus.redirect_valid), 0);
    chk("t1_pc4_hold",  bus.upd_pc4, 32'h104);

    // Fill to full, overflow push ignored, drain in order with wrap
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(4*i), 32'h80, 1'b1);
    chk("t2_full_ready", 32'(bus.push_ready), 0);
    chk("t2_full_occ",   32'(bus.occupancy), 4);
    push(32'h99, 32'h80, 1'b1);
    chk("t2_ovf_occ",    32'(bus.occupancy), 4);
    for (int i = 0; i < 4; i++) begin
      resolve(c_BNE, 1'b0);
      chk("t2_upd",   32'(bus.upd_valid), 1);
      chk("t2_pc4",   bus.upd_pc4, 32'h10 + 32'(4*i));
      chk("t2_wrong", 32'(bus.upd_pred_wrong), 0);
      chk("t2_redir", 32'(bus.redirect_valid), 0);
    end
    chk("t2_occ",  32'(bus.occupancy), 0);
    chk("t2_bcnt", 32'(bus.branch_cnt), 5);
    chk("t2_mcnt", 32'(bus.mispred_cnt), 1);

    // Mispredict flushes younger entries and drops the racing push
    push(32'h20, 32'h300, 1'b0);
    push(32'h24, 32'h300, 1'b0);
    push(32'h28, 32'h300, 1'b0);
    bus.push_valid = 1'b1; bus.push_pc4 = 32'h2c; bus.push_target = 32'h0; bus.push_pred_taken = 1'b0;
    resolve(c_BEQ, 1'b1);
    bus.push_valid = 1'b0;
    chk("t3_occ",   32'(bus.occupancy), 0);
    chk("t3_redir", 32'(bus.redirect_valid), 1);
    chk("t3_rpc",   bus.redirect_pc, 32'h300);
    chk("t3_bcnt",  32'(bus.branch_cnt), 6);
    chk("t3_mcnt",  32'(bus.mispred_cnt), 2);
    push(32'h40, 32'h500, 1'b1);
    resolve(c_BNE, 1'b0);
    chk("t3_next_pc4", bus.upd_pc4, 32'h40);
    chk("t3_next_occ", 32'(bus.occupancy), 0);

    // Correct resolve with simultaneous push keeps count and order
    push(32'h50, 32'h600, 1'b0);
    push(32'h54, 32'h600, 1'b0);
    push_resolve(32'h58, 1'b0, c_BEQ, 1'b0);
    chk("t4_occ",   32'(bus.occupancy), 2);
    chk("t4_pc4a",  bus.upd_pc4, 32'h50);
    chk("t4_wrong", 32'(bus.upd_pred_wrong), 0);
    chk("t4_taken", 32'(bus.upd_real_taken), 0);
    resolve(c_BNE, 1'b1);
    chk("t4_pc4b",  bus.upd_pc4, 32'h54);
    resolve(c_BNE, 1'b1);
    chk("t4_pc4c",  bus.upd_pc4, 32'h58);
    chk("t4_bcnt",  32'(bus.branch_cnt), 10);

    // Protocol errors: empty queue, illegal opcode
    resolve(c_BEQ, 1'b0);
    chk("t5_err_empty", 32'(bus.err), 1);
    chk("t5_upd_empty", 32'(bus.upd_valid), 0);
    chk("t5_bcnt_empty",32'(bus.branch_cnt), 10);
    push(32'h60, 32'h700, 1'b0);
    resolve(6'b000000, 1'b0);
    chk("t5_upd_op",    32'(bus.upd_valid), 0);
    chk("t5_occ_op",    32'(bus.occupancy), 1);
    chk("t5_bcnt_op",   32'(bus.branch_cnt), 10);
    resolve(c_BEQ, 1'b0);
    chk("t5_pc4_after", bus.upd_pc4, 32'h60);
    chk("t5_err_sticky",32'(bus.err), 1);
    chk("t5_bcnt_after",32'(bus.branch_cnt), 11);

    // Saturation of the 4-bit branch counter
    for (int i = 0; i < 4; i++) begin
      push(32'h100 + 32'(4*i), 32'h0, 1'b0);
      resolve(c_BEQ, 1'b0);
    end
    chk("t6_bcnt_max", 32'(bus.branch_cnt), 15);
    for (int i = 0; i < 2; i++) begin
      push(32'h200 + 32'(4*i), 32'h0, 1'b0);
      resolve(c_BEQ, 1'b0);
    end
    chk("t6_bcnt_sat", 32'(bus.branch_cnt), 15);
    chk("t6_mcnt",     32'(bus.mispred_cnt), 2);

    // Asynchronous reset mid-stream
    push(32'h300, 32'h0, 1'b0);
    push(32'h304, 32'h0, 1'b0);
    push(32'h308, 32'h0, 1'b0);
    resolve(c_BEQ, 1'b0);
    chk("t7_pre_upd", 32'(bus.upd_valid), 1);
    chk("t7_pre_occ", 32'(bus.occupancy), 2);
    #1 rst = 1'b1;
    #1;
    chk("t7_occ",   32'(bus.occupancy), 0);
    chk("t7_upd",   32'(bus.upd_valid), 0);
    chk("t7_pc4",   bus.upd_pc4, 0);
    chk("t7_err",   32'(bus.err), 0);
    chk("t7_bcnt",  32'(bus.branch_cnt), 0);
    chk("t7_mcnt",  32'(bus.mispred_cnt), 0);
    chk("t7_ready", 32'(bus.push_ready), 1);
    #1 rst = 1'b0;
    cyc();
    push(32'h70, 32'h0, 1'b0);
    resolve(c_BEQ, 1'b0);
    chk("t7_post_pc4", bus.upd_pc4, 32'h70);
    chk("t7_post_occ", 32'(bus.occupancy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order tracker for branch predictions in flight between IF (where a prediction is made) and ID (where the branch resolves).
- Pushed once per fetched BEQ/BNE with its predicted direction.
- Popped when ID resolves that branch.
- Produces the per-branch predictor update (pc4, predWrong, realTaken), the front-end redirect/flush on a mispredict, and saturating branch/mispredict statistics.

Parameters:
DEPTH, 4, queue entries (power of 2, >=2)
PTR_BITS, 2, log2(DEPTH)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
push_valid  in  1  IF issues a predicted BEQ/BNE this cycle
push_ready  out  1  queue not full; push accepted when push_valid && push_ready
push_pc4  in  32  PC+4 of the branch
push_target  in  32  branch target address
push_pred_taken  in  1  direction predicted in IF
resolve_valid  in  1  ID resolves the oldest outstanding branch
resolve_opcode  in  6  opcode in ID (BEQ=6'b000100, BNE=6'b000101)
resolve_equal  in  1  register compare result in ID
upd_valid  out  1  predictor update strobe, one cycle
upd_pc4  out  32  PC+4 of the resolved branch (predictor index = upd_pc4[8:2])
upd_pred_wrong  out  1  prediction was wrong
upd_real_taken  out  1  actual direction
redirect_valid  out  1  mispredict; front end must fetch redirect_pc
redirect_pc  out  32  real_taken ? target : pc4
occupancy  out  PTR_BITS+1  entries held
err  out  1  sticky protocol error
branch_cnt  out  CNT_W  resolved branches, saturating
mispred_cnt  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset (async, rst=1): queue empty, pointers 0, occupancy 0, push_ready 1, all upd_*/redirect_* outputs 0, err 0, both counters 0. Reset asserted mid-operation discards all entries immediately.
- Storage: circular buffer of {pc4, target, pred_taken}.
  - head/tail pointers are PTR_BITS wide and wrap DEPTH-1 -> 0.
  - Full/empty is tracked by a separate count (0..DEPTH).
- push_ready = (count != DEPTH), combinational. Push while full: ignored, no state change.
- Resolve handshake:
  - Accepted when resolve_valid && count != 0 && opcode in {BEQ, BNE}. Pops the head entry.
  - real_taken: BEQ -> resolve_equal; BNE -> !resolve_equal.
  - wrong = real_taken ^ head.pred_taken.
- resolve_valid with an empty queue, or with any other opcode: no pop, err <= 1 (held until reset), no update strobe.
- Outputs registered, latency 1: at the edge after an accepted resolve:
  - upd_valid=1 with upd_pc4/upd_pred_wrong/upd_real_taken from the popped entry.
  - redirect_valid=wrong; redirect_pc computed per the port definition.
- Both strobes deassert the following cycle unless another resolve is accepted. Data outputs hold their last value when the strobe is 0.
- Flush: an accepted resolve with wrong=1 empties the whole queue at that same edge (head popped, all younger wrong-path entries discarded, count=0, head=tail).
- Simultaneous push and resolve in one cycle:
  - Correct prediction: both happen; count unchanged; push accepted even at count==DEPTH only if push_ready was already 1 (push_ready does not look at the resolve).
  - Wrong prediction: the push is dropped (wrong path); count=0 after the edge.
- Counters:
  - branch_cnt += 1 per accepted resolve.
  - mispred_cnt += 1 per accepted wrong resolve.
  - Both saturate at all-ones and never wrap.

Test Plan:
- Reset then push pc4=0x104, target=0x200, pred=0; resolve BEQ equal=1 -> next cycle upd_valid=1, upd_pc4=0x104, upd_pred_wrong=1, upd_real_taken=1, redirect_valid=1, redirect_pc=0x200, occupancy=0, mispred_cnt=1.
- Push 4 entries (pred=1, BNE) -> push_ready=0 after the 4th; 5th push ignored. Resolve 4 BNE with equal=0 -> 4 updates in order, pred_wrong=0, no redirect, occupancy back to 0, pointers wrapped.
- Queue holds 3 entries; resolve head mispredicted while push_valid=1 -> occupancy=0 next cycle, pushed entry absent, branch_cnt +1.
- Queue holds 2 entries, correct resolve plus push in the same cycle -> occupancy stays 2, FIFO order preserved on the next two resolves.
- resolve_valid with an empty queue, or with opcode=6'b000000 -> err=1 and stays 1, no upd_valid, counters unchanged; assert rst mid-stream -> all outputs 0 asynchronously.
- Force branch_cnt to 2^CNT_W-1 via resolves -> stays at all-ones after further resolves.
